// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit.
//   redir_kind_e : encoding of the redirect kind carried on redir_kind
//   DEFAULT_*    : default vectors and sizing used by pc_unit parameters
package pc_pkg;

    typedef enum logic [1:0] {
        KIND_JUMP = 2'd0,
        KIND_CALL = 2'd1,
        KIND_RET  = 2'd2,
        KIND_ERET = 2'd3
    } redir_kind_e;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0080;
    localparam int unsigned DEFAULT_INC          = 32'd4;
    localparam int unsigned DEFAULT_RAS_DEPTH    = 32'd4;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack. The newest entry is always on top; a push
// while full overwrites the oldest entry and raises the sticky ovf flag, a pop
// while empty leaves the stack alone and raises the sticky unf flag.
// State changes on the falling edge of clk.
//   clk, rst_n  : clock (falling-edge active) and async active-low reset
//   push, pop   : stack operations (push wins if both are asserted)
//   push_data   : value pushed
//   top         : current top entry (meaningful only when !empty)
//   empty, full : occupancy status
//   ovf, unf    : sticky overflow / underflow, cleared only by reset
module pc_ras #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             full,
    output logic             ovf,
    output logic             unf
);

    localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RAS_DEPTH);

    logic [WIDTH-1:0] mem_r [RAS_DEPTH];
    logic [PTR_W-1:0] top_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             ovf_r;
    logic             unf_r;
    logic [PTR_W-1:0] push_ptr_s;
    logic [PTR_W-1:0] pop_ptr_s;

    // Depth is a power of two, so pointer arithmetic wraps the ring for free.
    assign push_ptr_s = top_ptr_r + PTR_W'(1);
    assign pop_ptr_s  = top_ptr_r - PTR_W'(1);

    // Stack storage, pointer, occupancy and sticky error flags.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(RAS_DEPTH); i++) begin
                mem_r[i] <= '0;
            end
            top_ptr_r <= '0;
            count_r   <= '0;
            ovf_r     <= 1'b0;
            unf_r     <= 1'b0;
        end else if (push) begin
            mem_r[push_ptr_s] <= push_data;
            top_ptr_r         <= push_ptr_s;
            if (count_r == DEPTH_C) begin
                // Oldest entry was just overwritten; occupancy stays at depth.
                ovf_r <= 1'b1;
            end else begin
                count_r <= count_r + CNT_W'(1);
            end
        end else if (pop) begin
            if (count_r == '0) begin
                unf_r <= 1'b1;
            end else begin
                top_ptr_r <= pop_ptr_s;
                count_r   <= count_r - CNT_W'(1);
            end
        end else begin
            top_ptr_r <= top_ptr_r;
        end
    end

    assign top   = mem_r[top_ptr_r];
    assign empty = (count_r == '0);
    assign full  = (count_r == DEPTH_C);
    assign ovf   = ovf_r;
    assign unf   = unf_r;

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit for the fetch front end. Holds the fetch PC and the
// exception PC, selects the next PC by priority (trap > stall > redirect >
// sequential) and drives the return-address stack for CALL/RET.
// All state updates on the falling edge of clk.
//   clk, rst_n           : clock (falling-edge active), async active-low reset
//   stall                : hold PC; does not block trap
//   redir_valid/kind/target : redirect request (JUMP/CALL/RET/ERET)
//   trap                 : exception request, jumps to TRAP_VECTOR
//   cur_pc               : registered current PC
//   nxt_pc               : combinational next PC
//   epc                  : PC of the last trapping instruction
//   ras_empty/full/ovf/unf : return-address stack status
module pc_unit
    import pc_pkg::*;
#(
    parameter int unsigned       WIDTH        = 32,
    parameter int unsigned       INC          = DEFAULT_INC,
    parameter logic [WIDTH-1:0]  RESET_VECTOR = WIDTH'(DEFAULT_RESET_VECTOR),
    parameter logic [WIDTH-1:0]  TRAP_VECTOR  = WIDTH'(DEFAULT_TRAP_VECTOR),
    parameter int unsigned       RAS_DEPTH    = DEFAULT_RAS_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             redir_valid,
    input  logic [1:0]       redir_kind,
    input  logic [WIDTH-1:0] redir_target,
    input  logic             trap,
    output logic [WIDTH-1:0] cur_pc,
    output logic [WIDTH-1:0] nxt_pc,
    output logic [WIDTH-1:0] epc,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_ovf,
    output logic             ras_unf
);

    logic [WIDTH-1:0] cur_pc_r;
    logic [WIDTH-1:0] epc_r;
    logic [WIDTH-1:0] pc_inc_s;
    logic [WIDTH-1:0] nxt_pc_s;
    logic [WIDTH-1:0] ras_top_s;
    logic             ras_empty_s;
    logic             push_s;
    logic             pop_s;
    logic             epc_load_s;

    // Sequential successor; wraps modulo 2^WIDTH by construction.
    assign pc_inc_s = cur_pc_r + WIDTH'(INC);

    // Next-PC priority mux and RAS / epc control strobes.
    always_comb begin
        nxt_pc_s   = pc_inc_s;
        push_s     = 1'b0;
        pop_s      = 1'b0;
        epc_load_s = 1'b0;
        if (trap) begin
            nxt_pc_s   = TRAP_VECTOR;
            epc_load_s = 1'b1;
        end else if (stall) begin
            nxt_pc_s = cur_pc_r;
        end else if (redir_valid) begin
            case (redir_kind_e'(redir_kind))
                KIND_ERET: nxt_pc_s = epc_r;
                KIND_RET: begin
                    // Pop is issued even when empty so the stack records underflow.
                    pop_s = 1'b1;
                    if (!ras_empty_s) begin
                        nxt_pc_s = ras_top_s;
                    end else begin
                        nxt_pc_s = redir_target;
                    end
                end
                KIND_CALL: begin
                    nxt_pc_s = redir_target;
                    push_s   = 1'b1;
                end
                KIND_JUMP: nxt_pc_s = redir_target;
                default:   nxt_pc_s = pc_inc_s;
            endcase
        end else begin
            nxt_pc_s = pc_inc_s;
        end
    end

    // PC and exception-PC registers.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_pc_r <= RESET_VECTOR;
            epc_r    <= '0;
        end else begin
            cur_pc_r <= nxt_pc_s;
            if (epc_load_s) begin
                epc_r <= cur_pc_r;
            end else begin
                epc_r <= epc_r;
            end
        end
    end

    pc_ras #(
        .WIDTH     (WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_s),
        .pop       (pop_s),
        .push_data (pc_inc_s),
        .top       (ras_top_s),
        .empty     (ras_empty_s),
        .full      (ras_full),
        .ovf       (ras_ovf),
        .unf       (ras_unf)
    );

    assign cur_pc    = cur_pc_r;
    assign nxt_pc    = nxt_pc_s;
    assign epc       = epc_r;
    assign ras_empty = ras_empty_s;

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the CPU front end: holds the current fetch address, advances sequentially, and accepts branch/jump, call, return, trap and trap-return redirects. It adds an asynchronous active-low reset, stall, a configurable-depth return-address stack (RAS) and an exception PC. It sits between the decode/branch-resolve logic and the instruction memory address port.

## Interface
- WIDTH, 32, PC and address width in bits
- INC, 4, sequential increment in bytes
- RESET_VECTOR, 0, PC value after reset
- TRAP_VECTOR, 32'h80, PC loaded on trap
- RAS_DEPTH, 4, return-address stack entries (power of two, ≥2)

Ports:
- clk  in  1  clock; all state updates on the falling edge
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  hold PC; blocks redirect and sequential advance, not trap
- redir_valid  in  1  redirect request this cycle
- redir_kind  in  2  JUMP=0, CALL=1, RET=2, ERET=3
- redir_target  in  WIDTH  target for JUMP/CALL; fallback for RET on empty RAS
- trap  in  1  exception request
- cur_pc  out  WIDTH  registered current PC
- nxt_pc  out  WIDTH  combinational next PC
- epc  out  WIDTH  PC of the trapping instruction
- ras_empty  out  1  RAS holds no entries
- ras_full  out  1  RAS holds RAS_DEPTH entries
- ras_ovf  out  1  sticky: push while full
- ras_unf  out  1  sticky: pop while empty

## Operation
- Reset (rst_n=0, asynchronous): cur_pc=RESET_VECTOR, epc=0, RAS count=0, top pointer=0, ras_ovf=ras_unf=0. ras_empty=1, ras_full=0.
- Next-PC selection, priority high to low:
  - trap: nxt_pc=TRAP_VECTOR; epc<=cur_pc. Ignores stall and redir_valid.
  - stall: nxt_pc=cur_pc; no RAS or epc change.
  - redir_valid, ERET: nxt_pc=epc.
  - redir_valid, RET: RAS non-empty: nxt_pc=top entry, pop. Empty: nxt_pc=redir_target, set ras_unf, count stays 0.
  - redir_valid, CALL: nxt_pc=redir_target; push cur_pc+INC.
  - redir_valid, JUMP: nxt_pc=redir_target.
  - otherwise: nxt_pc=cur_pc+INC.
- Arithmetic: cur_pc+INC is computed modulo 2^WIDTH and wraps silently (all-ones region → low addresses). No alignment check.
- RAS is circular. Push while full overwrites the oldest entry, count stays RAS_DEPTH, and sets ras_ovf. The newest entry is always on top.
- Sticky flags clear only on reset.
- Trap with a simultaneous CALL/RET: trap wins, and the RAS is untouched.

## Timing
- nxt_pc is combinational from the current state and inputs, with zero latency.
- cur_pc, epc, RAS and flags update on the falling edge of clk. Inputs must be stable around each falling edge.
- Redirect latency is one falling edge: the target appears on cur_pc after the edge that samples redir_valid.
- RAS push and pop take effect on the same edge as the PC update. A CALL immediately followed by a RET returns the pushed value.
- rst_n assertion mid-operation clears all state immediately, independent of clk. Deassertion is synchronised externally; the first update occurs on the next falling edge.

## Structure
- Shared package pc_pkg holds the redir_kind constants (KIND_JUMP, KIND_CALL, KIND_RET, KIND_ERET) and the default vector constants.
- Sub-module pc_ras is the circular stack. It has WIDTH and RAS_DEPTH parameters, push/pop/push_data inputs, and top/empty/full/ovf/unf outputs, and uses the same clk/rst_n.
- pc_unit holds the PC register, the epc register, the priority mux and the incrementer.

## Test plan
- Reset then 3 free-running falling edges with RESET_VECTOR=0 → cur_pc 0, 4, 8, 0xC. Assert rst_n=0 mid-cycle → cur_pc=0 immediately.
- At cur_pc=0x100, CALL to 0x400; JUMP to 0x500; RET → cur_pc sequence 0x400, 0x500, 0x104. ras_empty=1 after the RET.
- RAS_DEPTH=4: 5 nested CALLs from PCs 0x10, 0x20, 0x30, 0x40, 0x50, then 5 RETs with redir_target=0xDEAD0 → returns 0x54, 0x44, 0x34, 0x24, then 0xDEAD0. Both ras_ovf and ras_unf end at 1.
- stall=1 with redir_valid JUMP 0x800 at cur_pc=0x200 → cur_pc stays 0x200. Then trap with stall=1 → cur_pc=0x80 and epc=0x200. Then ERET → cur_pc=0x200.
- WIDTH=32, cur_pc=0xFFFFFFFC, no redirect → next cur_pc=0x00000000.
- Same-cycle trap and CALL at cur_pc=0x300 → cur_pc=0x80, epc=0x300, RAS count unchanged.
